regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of entries in the multi-cycle-unit request buffer (power of two, at least 2).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive lost-arbitration cycles before a pipeline stall is requested (1..15).
REQ-003 clk  in  1  system clock; all state SHALL update on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wbValid  in  1  pipeline writeback request; it SHALL have no backpressure.
REQ-006 wbAddr  in  5  pipeline destination register.
REQ-007 wbData  in  32  pipeline write data.
REQ-008 mdValid  in  1  multi-cycle unit (mult/div) write request.
REQ-009 mdReady  out  1  the arbiter can accept an md request this cycle.
REQ-010 mdAddr  in  5  md destination register.
REQ-011 mdData  in  32  md write data.
REQ-012 writeEn  out  1  register-file write enable.
REQ-013 writeAddr  out  5  register-file write address.
REQ-014 writeData  out  32  register-file write data.
REQ-015 stallReq  out  1  registered request for the hazard unit to insert a writeback bubble.
REQ-016 pendingMask  out  32  bit n SHALL be set while any buffered md entry targets register n.

Function
REQ-017 The md handshake SHALL complete when mdValid and mdReady are both high at posedge.
REQ-018 mdReady SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on a same-cycle drain.
REQ-019 An accepted md request with mdAddr = 0 SHALL be discarded and not enqueued.
REQ-020 When the buffer is empty, the md request SHALL still be enqueued and SHALL NOT bypass to the write port; md write latency is at least 1 cycle.
REQ-021 The write port SHALL be driven combinationally from the current-cycle state, so the register file captures the write on the same cycle's negedge.
REQ-022 When wbValid is high, the write port SHALL carry the wb request (fixed priority) and the buffer head SHALL be held.
REQ-023 When wbValid is low and the buffer is non-empty, the write port SHALL carry the head entry, and the head SHALL be popped at posedge.
REQ-024 When neither source is requesting, writeEn SHALL be 0 and writeAddr/writeData SHALL be 0.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged, with both pointers advancing modulo DEPTH.
REQ-026 starveCnt SHALL increment on each cycle the buffer is non-empty and wbValid is high, saturating at STARVE_LIMIT.
REQ-027 starveCnt SHALL clear on any head pop.
REQ-028 stallReq SHALL be registered high the cycle after starveCnt reaches STARVE_LIMIT, and SHALL fall the cycle after the head pops.
REQ-029 If wbValid stays high while stallReq is high (protocol violation), wb SHALL still win, no data SHALL be lost, and stallReq SHALL stay high.
REQ-030 pendingMask SHALL be the OR of the one-hot decodes of all valid entries; it SHALL update one cycle after a push or pop.
REQ-031 Same-address ordering between wb and md SHALL be the hazard unit's responsibility, using pendingMask.

Reset
REQ-032 On rst: count, pointers and starveCnt SHALL be 0; stallReq = 0; pendingMask = 0; mdReady = 1; writeEn = 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries with no write issued.

Structure
REQ-034 The package cpu_pkg SHALL hold typedef wb_req_t {addr[4:0], data[31:0]} and REG_ADDR_W = 5, DATA_W = 32.
REQ-035 The buffer SHALL be a sub-module wb_req_fifo (DEPTH entries of wb_req_t) with push/pop/full/empty/count/entry-valid outputs.

Verification
REQ-036 Empty buffer, md {addr 5, data 0x1234} with wbValid = 0: the same-cycle write port is idle; the next cycle writes r5 = 0x1234; pendingMask bit 5 is high for exactly 1 cycle.
REQ-037 wbValid high 6 consecutive cycles with one buffered md to r7: stallReq rises after 4 lost cycles; the first cycle with wbValid = 0 writes r7; stallReq falls the next cycle.
REQ-038 Two md pushes with wbValid high: mdReady drops to 0; a third mdValid is held without loss; after one pop, mdReady returns to 1.
REQ-039 md request to r0: it is accepted, no write occurs, and pendingMask stays 0.
REQ-040 rst pulsed with 2 buffered entries: all outputs return to reset values immediately, and r-writes never occur for those entries.
REQ-041 Simultaneous push and pop at count 1: count stays 1, and the entries are written in FIFO order.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file writeback path.
// Holds the writeback request record and a register one-hot decode helper.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    reg_onehot = 32'd1 << a;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Small circular buffer of pending multi-cycle-unit writeback requests.
// Exposes every slot plus a per-slot valid vector so the owner can build a pending-register mask.
module wb_req_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_req_t               din_i,
  input  logic                  pop_i,
  output wb_req_t               head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [DEPTH-1:0]      valid_o,
  output wb_req_t [DEPTH-1:0]   entries_o
);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    push_mask_s, pop_mask_s;
  wb_req_t [DEPTH-1:0] mem_q;
  logic                do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  assign push_mask_s = do_push_s ? (DEPTH'(1) << wr_ptr_q) : {DEPTH{1'b0}};
  assign pop_mask_s  = do_pop_s  ? (DEPTH'(1) << rd_ptr_q) : {DEPTH{1'b0}};

  // Next-state for pointers, occupancy and slot-valid bits.
  always_comb begin
    wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    valid_d  = (valid_q | push_mask_s) & ~pop_mask_s;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; stale slots are masked by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign valid_o   = valid_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback (fixed priority)
// and buffered mult/div results, requesting a pipeline bubble when the buffer head starves.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0]     wbData,
  input  logic                  mdValid,
  output logic                  mdReady,
  input  logic [REG_ADDR_W-1:0] mdAddr,
  input  logic [DATA_W-1:0]     mdData,
  output logic                  writeEn,
  output logic [REG_ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0]     writeData,
  output logic                  stallReq,
  output logic [31:0]           pendingMask
);

  localparam int         CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic [DEPTH-1:0]    fifo_valid_s;
  wb_req_t [DEPTH-1:0] fifo_entries_s;
  wb_req_t             fifo_head_s;
  wb_req_t             md_req_s;
  logic                push_s, pop_s;
  logic [3:0]          starve_q, starve_d;
  logic                stall_q, stall_d;

  assign md_req_s = '{addr: mdAddr, data: mdData};
  assign mdReady  = (fifo_count_s < CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but are dropped here.
  assign push_s   = mdValid && !fifo_full_s && (mdAddr != 5'd0);

  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_s),
    .din_i     (md_req_s),
    .pop_i     (pop_s),
    .head_o    (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s),
    .valid_o   (fifo_valid_s),
    .entries_o (fifo_entries_s)
  );

  // Write-port selection; the register file samples this on the falling edge.
  always_comb begin
    writeEn   = 1'b0;
    writeAddr = 5'd0;
    writeData = 32'd0;
    pop_s     = 1'b0;
    if (rst) begin
      pop_s = 1'b0;
    end else if (wbValid) begin
      writeEn   = 1'b1;
      writeAddr = wbAddr;
      writeData = wbData;
    end else if (!fifo_empty_s) begin
      writeEn   = 1'b1;
      writeAddr = fifo_head_s.addr;
      writeData = fifo_head_s.data;
      pop_s     = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Starvation counter and stall request next-state.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop_s) begin
      starve_d = 4'd0;
    end else if (!fifo_empty_s && wbValid && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    if (pop_s) begin
      stall_d = 1'b0;
    end else if (starve_q == STARVE_MAX) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Starvation state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stallReq = stall_q;

  // Pending-register mask over all occupied buffer slots.
  always_comb begin
    pendingMask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pendingMask = pendingMask |
                    (fifo_valid_s[i] ? reg_onehot(fifo_entries_s[i].addr) : 32'd0);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus queues the expected register writes,
// a negedge monitor pops and compares every write-port transaction.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        mdValid;
  logic        mdReady;
  logic [4:0]  mdAddr;
  logic [31:0] mdData;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        stallReq;
  logic [31:0] pendingMask;

  int          checks;
  int          errors;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wbValid     (wbValid),
    .wbAddr      (wbAddr),
    .wbData      (wbData),
    .mdValid     (mdValid),
    .mdReady     (mdReady),
    .mdAddr      (mdAddr),
    .mdData      (mdData),
    .writeEn     (writeEn),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .stallReq    (stallReq),
    .pendingMask (pendingMask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_w(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wbValid = wv; wbAddr = wa; wbData = wd;
    mdValid = mv; mdAddr = ma; mdData = md;
    if (wv) exp_w(wa, wd);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write-port transaction must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (writeEn) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got r%0d=%h expected no write", writeAddr, writeData);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          if (writeAddr !== e[36:32] || writeData !== e[31:0]) begin
            errors++;
            $display("FAIL write: got r%0d=%h expected r%0d=%h",
                     writeAddr, writeData, e[36:32], e[31:0]);
          end
        end
      end else begin
        checks++;
        if (writeAddr !== 5'd0 || writeData !== 32'd0) begin
          errors++;
          $display("FAIL idle_port: got r%0d=%h expected r0=0", writeAddr, writeData);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("rst_mdReady", 32'(mdReady), 32'd1);
    chk("rst_stallReq", 32'(stallReq), 32'd0);
    chk("rst_pending", pendingMask, 32'd0);
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    next_cyc();
    rst = 1'b0;

    // md to r5 on empty buffer: no bypass, written next cycle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    exp_w(5'd5, 32'h1234);
    @(negedge clk);
    chk("md5_same_cycle_wen", 32'(writeEn), 32'd0);
    chk("md5_pending_pre", pendingMask, 32'd0);
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("md5_wen", 32'(writeEn), 32'd1);
    chk("md5_pending", pendingMask, 32'h0000_0020);
    next_cyc();
    @(negedge clk);
    chk("md5_pending_after", pendingMask, 32'd0);

    // md to r0 is accepted and dropped
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
    @(negedge clk);
    chk("r0_ready", 32'(mdReady), 32'd1);
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("r0_wen", 32'(writeEn), 32'd0);
    chk("r0_pending", pendingMask, 32'd0);

    // Starvation: one md to r7, then six wb cycles
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      next_cyc();
      drive(1'b1, 5'(10 + i), 32'hA000 + 32'(i), 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("starve_pending", pendingMask, 32'h0000_0080);
      if (i <= 4) chk("starve_stall_low", 32'(stallReq), 32'd0);
      if (i == 6) chk("starve_stall_high", 32'(stallReq), 32'd1);
    end
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_w(5'd7, 32'h77);
    @(negedge clk);
    chk("starve_pop_wen", 32'(writeEn), 32'd1);
    chk("starve_stall_hold", 32'(stallReq), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("starve_stall_fall", 32'(stallReq), 32'd0);
    chk("starve_pending_clr", pendingMask, 32'd0);

    // Fill to DEPTH under wb, hold a third request, then push+pop at count 1
    next_cyc();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h88);
    @(negedge clk);
    chk("fill_ready0", 32'(mdReady), 32'd1);
    next_cyc();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("fill_ready1", 32'(mdReady), 32'd1);
    next_cyc();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hAA);
    @(negedge clk);
    chk("full_ready", 32'(mdReady), 32'd0);
    chk("full_pending", pendingMask, 32'h0000_0300);
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA);
    exp_w(5'd8, 32'h88);
    @(negedge clk);
    chk("held_ready", 32'(mdReady), 32'd0);
    chk("held_stall", 32'(stallReq), 32'd0);
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA);
    exp_w(5'd9, 32'h99);
    @(negedge clk);
    chk("pushpop_ready", 32'(mdReady), 32'd1);
    chk("pushpop_pending", pendingMask, 32'h0000_0200);
    next_cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_w(5'd10, 32'hAA);
    @(negedge clk);
    chk("count1_ready", 32'(mdReady), 32'd1);
    chk("count1_pending", pendingMask, 32'h0000_0400);
    next_cyc();
    @(negedge clk);
    chk("drain_pending", pendingMask, 32'd0);

    // Reset with two buffered entries discards them
    next_cyc();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hCC);
    @(negedge clk);
    next_cyc();
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd13, 32'hDD);
    @(negedge clk);
    next_cyc();
    drive(1'b1, 5'd11, 32'hBB, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("prerst_pending", pendingMask, 32'h0000_3000);
    chk("prerst_ready", 32'(mdReady), 32'd0);
    #1;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("midrst_ready", 32'(mdReady), 32'd1);
    chk("midrst_stall", 32'(stallReq), 32'd0);
    chk("midrst_pending", pendingMask, 32'd0);
    chk("midrst_wen", 32'(writeEn), 32'd0);
    next_cyc();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_pending", pendingMask, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
